// File: rtl/br_pkg.sv
// Shared branch-resolution types and constants.
// Metadata bundle layout matches the fetch-side predictor.
package br_pkg;

  localparam int BR_N         = 12;
  localparam int BR_RAS_DEPTH = 16;
  localparam int BR_RAS_W     = 4;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [31:0]                pred_pc;
    logic                       pred_taken;
    logic                       gshare_taken;
    logic                       local_taken;
    logic [BR_N-1:0]            ghr;
    logic [BR_N-1:0]            lht;
    logic [BR_RAS_W-1:0]        ras_sp;
    logic [BR_RAS_DEPTH*32-1:0] ras;
  } spec_meta_t;

  typedef struct packed {
    logic       valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    spec_meta_t  meta;
  } id_ex_t;

  typedef enum logic {
    SQ_NORMAL,
    SQ_SQUASH
  } sq_state_e;

endpackage

// File: rtl/br_resolve_unit_cmp.sv
// Conditional-branch comparator: func3 and operands to taken.
// Reserved func3 encodings resolve not-taken.
module br_cmp
  import br_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken
);

  always_comb begin
    taken = 1'b0;
    unique case (func3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) < $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 < rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/br_resolve_unit.sv
// Execute-stage branch resolution, redirect and predictor training.
// Wrong-path decode handshakes are squashed after each redirect.
module br_resolve_unit
  import br_pkg::*;
#(
  parameter int N            = BR_N,
  parameter int RAS_DEPTH    = BR_RAS_DEPTH,
  parameter int RAS_W        = BR_RAS_W,
  parameter int SQUASH_DEPTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   d_valid,
  input  logic                   e_allow_in,
  input  logic [31:0]            d_pc,
  input  logic [31:0]            d_pred_pc,
  input  logic [31:0]            d_imm,
  input  logic [6:0]             d_opcode,
  input  logic [2:0]             d_func3,
  input  logic                   d_is_jump_instr,
  input  logic                   d_pred_taken,
  input  logic                   d_gshare_taken,
  input  logic                   d_local_taken,
  input  logic [N-1:0]           d_ghr_snapshot,
  input  logic [N-1:0]           d_lht_snapshot,
  input  logic [RAS_W-1:0]       d_ras_sp,
  input  logic [RAS_DEPTH*32-1:0] d_ras_snapshot,
  input  logic [31:0]            e_rs1_val,
  input  logic [31:0]            e_rs2_val,
  output logic                   e_stage_valid,
  output logic                   e_stage_is_jump_instr,
  output logic                   e_actual_taken,
  output logic                   e_pred_correct,
  output logic                   e_is_cond_br,
  output logic                   e_is_jalr,
  output logic [31:0]            e_pc,
  output logic [31:0]            e_redirect_pc,
  output logic [31:0]            e_imm,
  output logic [2:0]             e_func3,
  output logic [N-1:0]           e_train_ghr_snapshot,
  output logic [N-1:0]           e_train_lht_snapshot,
  output logic [RAS_W-1:0]       e_train_ras_sp,
  output logic [RAS_DEPTH*32-1:0] e_train_ras_snapshot,
  output logic                   e_train_gshare_taken,
  output logic                   e_train_local_taken,
  output logic                   e_flush,
  output logic [31:0]            br_cnt,
  output logic [31:0]            mispred_cnt
);

  id_ex_t      e_q, e_d;
  sq_state_e   state_q, state_d;
  logic [1:0]  sq_cnt_q, sq_cnt_d;
  logic        rd_done_q, rd_done_d;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  logic        is_cond, is_jal, is_jalr, is_jump;
  logic        cmp_taken, act_taken, pred_ok;
  logic [31:0] target, seq_pc, redir;
  logic        cnt_en;

  // Jump class is re-derived from the latched opcode.
  logic unused_d_jump;
  assign unused_d_jump = d_is_jump_instr;

  assign is_cond = e_q.valid & (e_q.opcode == OPC_BRANCH);
  assign is_jal  = e_q.valid & (e_q.opcode == OPC_JAL);
  assign is_jalr = e_q.valid & (e_q.opcode == OPC_JALR);
  assign is_jump = is_cond | is_jal | is_jalr;
  assign seq_pc  = e_q.pc + 32'd4;

  br_cmp u_cmp (
    .func3 (e_q.func3),
    .rs1   (e_rs1_val),
    .rs2   (e_rs2_val),
    .taken (cmp_taken)
  );

  always_comb begin
    target = seq_pc;
    unique case (1'b1)
      is_jalr:         target = (e_rs1_val + e_q.imm) & ~32'h1;
      is_cond, is_jal: target = e_q.pc + e_q.imm;
      default:         target = seq_pc;
    endcase
  end

  assign act_taken = is_cond ? cmp_taken : (is_jal | is_jalr);
  assign redir     = !e_q.valid ? 32'h0 : (act_taken ? target : seq_pc);
  assign pred_ok   = e_q.valid &
                     (!is_jump |
                      ((e_q.meta.pred_taken == act_taken) &
                       (e_q.meta.pred_pc == redir)));

  assign e_flush       = is_jump & ~pred_ok & ~rd_done_q;
  assign e_stage_valid = e_q.valid & ~rd_done_q;
  assign cnt_en        = e_stage_valid & is_jump & e_allow_in;

  always_comb begin
    e_d = e_q;
    if (e_allow_in) begin
      e_d.valid             = d_valid & ~e_flush & (state_q == SQ_NORMAL);
      e_d.pc                = d_pc;
      e_d.imm               = d_imm;
      e_d.opcode            = d_opcode;
      e_d.func3             = d_func3;
      e_d.meta.pred_pc      = d_pred_pc;
      e_d.meta.pred_taken   = d_pred_taken;
      e_d.meta.gshare_taken = d_gshare_taken;
      e_d.meta.local_taken  = d_local_taken;
      e_d.meta.ghr          = d_ghr_snapshot;
      e_d.meta.lht          = d_lht_snapshot;
      e_d.meta.ras_sp       = d_ras_sp;
      e_d.meta.ras          = d_ras_snapshot;
    end
  end

  // One flush per instruction: latch it until E advances.
  assign rd_done_d = e_allow_in ? 1'b0 : (rd_done_q | e_flush);

  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    if (e_flush) begin
      state_d  = SQ_SQUASH;
      sq_cnt_d = 2'(SQUASH_DEPTH);
    end else if (state_q == SQ_SQUASH && d_valid && e_allow_in) begin
      sq_cnt_d = sq_cnt_q - 2'd1;
      if (sq_cnt_q == 2'd1) state_d = SQ_NORMAL;
    end
  end

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (cnt_en && br_cnt_q != 32'hFFFF_FFFF)
      br_cnt_d = br_cnt_q + 32'd1;
    if (cnt_en && !pred_ok && mis_cnt_q != 32'hFFFF_FFFF)
      mis_cnt_d = mis_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q       <= '0;
      state_q   <= SQ_NORMAL;
      sq_cnt_q  <= 2'd0;
      rd_done_q <= 1'b0;
      br_cnt_q  <= 32'd0;
      mis_cnt_q <= 32'd0;
    end else begin
      e_q       <= e_d;
      state_q   <= state_d;
      sq_cnt_q  <= sq_cnt_d;
      rd_done_q <= rd_done_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign e_stage_is_jump_instr = is_jump;
  assign e_actual_taken        = act_taken;
  assign e_pred_correct        = pred_ok;
  assign e_is_cond_br          = is_cond;
  assign e_is_jalr             = is_jalr;
  assign e_pc                  = e_q.pc;
  assign e_redirect_pc         = redir;
  assign e_imm                 = e_q.imm;
  assign e_func3               = e_q.func3;
  assign e_train_ghr_snapshot  = e_q.meta.ghr;
  assign e_train_lht_snapshot  = e_q.meta.lht;
  assign e_train_ras_sp        = e_q.meta.ras_sp;
  assign e_train_ras_snapshot  = e_q.meta.ras;
  assign e_train_gshare_taken  = e_q.meta.gshare_taken;
  assign e_train_local_taken   = e_q.meta.local_taken;
  assign br_cnt                = br_cnt_q;
  assign mispred_cnt           = mis_cnt_q;

endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed bench for br_resolve_unit.
// Each scenario task carries its own inline comparisons.
module tb_br_resolve_unit;
  import br_pkg::*;

  localparam logic [6:0] OPC_ADD = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_valid, e_allow_in;
  logic [31:0] d_pc, d_pred_pc, d_imm;
  logic [6:0]  d_opcode;
  logic [2:0]  d_func3;
  logic        d_is_jump_instr, d_pred_taken;
  logic        d_gshare_taken, d_local_taken;
  logic [11:0] d_ghr_snapshot, d_lht_snapshot;
  logic [3:0]  d_ras_sp;
  logic [511:0] d_ras_snapshot;
  logic [31:0] e_rs1_val, e_rs2_val;
  logic        e_stage_valid, e_stage_is_jump_instr;
  logic        e_actual_taken, e_pred_correct;
  logic        e_is_cond_br, e_is_jalr;
  logic [31:0] e_pc, e_redirect_pc, e_imm;
  logic [2:0]  e_func3;
  logic [11:0] e_train_ghr_snapshot, e_train_lht_snapshot;
  logic [3:0]  e_train_ras_sp;
  logic [511:0] e_train_ras_snapshot;
  logic        e_train_gshare_taken, e_train_local_taken;
  logic        e_flush;
  logic [31:0] br_cnt, mispred_cnt;

  int checks = 0;
  int failures = 0;

  br_resolve_unit dut (
    .clk                   (clk),
    .rst                   (rst),
    .d_valid               (d_valid),
    .e_allow_in            (e_allow_in),
    .d_pc                  (d_pc),
    .d_pred_pc             (d_pred_pc),
    .d_imm                 (d_imm),
    .d_opcode              (d_opcode),
    .d_func3               (d_func3),
    .d_is_jump_instr       (d_is_jump_instr),
    .d_pred_taken          (d_pred_taken),
    .d_gshare_taken        (d_gshare_taken),
    .d_local_taken         (d_local_taken),
    .d_ghr_snapshot        (d_ghr_snapshot),
    .d_lht_snapshot        (d_lht_snapshot),
    .d_ras_sp              (d_ras_sp),
    .d_ras_snapshot        (d_ras_snapshot),
    .e_rs1_val             (e_rs1_val),
    .e_rs2_val             (e_rs2_val),
    .e_stage_valid         (e_stage_valid),
    .e_stage_is_jump_instr (e_stage_is_jump_instr),
    .e_actual_taken        (e_actual_taken),
    .e_pred_correct        (e_pred_correct),
    .e_is_cond_br          (e_is_cond_br),
    .e_is_jalr             (e_is_jalr),
    .e_pc                  (e_pc),
    .e_redirect_pc         (e_redirect_pc),
    .e_imm                 (e_imm),
    .e_func3               (e_func3),
    .e_train_ghr_snapshot  (e_train_ghr_snapshot),
    .e_train_lht_snapshot  (e_train_lht_snapshot),
    .e_train_ras_sp        (e_train_ras_sp),
    .e_train_ras_snapshot  (e_train_ras_snapshot),
    .e_train_gshare_taken  (e_train_gshare_taken),
    .e_train_local_taken   (e_train_local_taken),
    .e_flush               (e_flush),
    .br_cnt                (br_cnt),
    .mispred_cnt           (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [31:0] pc, input logic [31:0] imm,
                       input logic [6:0] opc, input logic [2:0] f3,
                       input logic pt, input logic [31:0] ppc);
    d_pc            = pc;
    d_imm           = imm;
    d_opcode        = opc;
    d_func3         = f3;
    d_pred_taken    = pt;
    d_pred_pc       = ppc;
    d_is_jump_instr = (opc == OPC_BRANCH) || (opc == OPC_JAL) ||
                      (opc == OPC_JALR);
    d_valid         = 1'b1;
    e_allow_in      = 1'b1;
    @(posedge clk);
    #1;
    d_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d_valid = 0; e_allow_in = 1; d_pc = 0; d_pred_pc = 0; d_imm = 0;
    d_opcode = 0; d_func3 = 0; d_is_jump_instr = 0; d_pred_taken = 0;
    d_gshare_taken = 0; d_local_taken = 0; d_ghr_snapshot = 0;
    d_lht_snapshot = 0; d_ras_sp = 0; d_ras_snapshot = '0;
    e_rs1_val = 0; e_rs2_val = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (e_stage_valid !== 1'b0) begin
      failures++; $display("FAIL rst_valid got=%h exp=0", e_stage_valid);
    end
    checks++;
    if (e_flush !== 1'b0) begin
      failures++; $display("FAIL rst_flush got=%h exp=0", e_flush);
    end
    checks++;
    if (e_redirect_pc !== 32'h0 || e_pred_correct !== 1'b0) begin
      failures++;
      $display("FAIL rst_outs got=%h/%h exp=0/0", e_redirect_pc, e_pred_correct);
    end
    checks++;
    if (br_cnt !== 32'h0 || mispred_cnt !== 32'h0) begin
      failures++; $display("FAIL rst_cnt got=%h/%h exp=0/0", br_cnt, mispred_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_beq();
    e_rs1_val = 32'd5; e_rs2_val = 32'd5;
    d_ghr_snapshot = 12'hABC; d_gshare_taken = 1'b1;
    issue(32'h100, 32'h20, OPC_BRANCH, F3_BEQ, 1'b1, 32'h120);
    checks++;
    if (e_stage_valid !== 1'b1 || e_actual_taken !== 1'b1) begin
      failures++;
      $display("FAIL beq_taken got=%h/%h exp=1/1", e_stage_valid, e_actual_taken);
    end
    checks++;
    if (e_pred_correct !== 1'b1 || e_flush !== 1'b0) begin
      failures++;
      $display("FAIL beq_ok got=%h/%h exp=1/0", e_pred_correct, e_flush);
    end
    checks++;
    if (e_redirect_pc !== 32'h120) begin
      failures++; $display("FAIL beq_redir got=%h exp=120", e_redirect_pc);
    end
    checks++;
    if (e_train_ghr_snapshot !== 12'hABC || e_train_gshare_taken !== 1'b1) begin
      failures++;
      $display("FAIL beq_train got=%h/%h exp=abc/1",
               e_train_ghr_snapshot, e_train_gshare_taken);
    end
    @(posedge clk); #1;
    checks++;
    if (br_cnt !== 32'd1 || mispred_cnt !== 32'd0) begin
      failures++; $display("FAIL beq_cnt got=%0d/%0d exp=1/0", br_cnt, mispred_cnt);
    end
  endtask

  task automatic test_bne_flush();
    e_rs1_val = 32'd7; e_rs2_val = 32'd7;
    issue(32'h200, 32'h40, OPC_BRANCH, F3_BNE, 1'b1, 32'h240);
    checks++;
    if (e_flush !== 1'b1 || e_pred_correct !== 1'b0) begin
      failures++;
      $display("FAIL bne_flush got=%h/%h exp=1/0", e_flush, e_pred_correct);
    end
    checks++;
    if (e_redirect_pc !== 32'h204 || e_actual_taken !== 1'b0) begin
      failures++;
      $display("FAIL bne_redir got=%h/%h exp=204/0", e_redirect_pc, e_actual_taken);
    end
    @(posedge clk); #1;
    checks++;
    if (e_flush !== 1'b0 || e_stage_valid !== 1'b0) begin
      failures++;
      $display("FAIL bne_pulse got=%h/%h exp=0/0", e_flush, e_stage_valid);
    end
    checks++;
    if (br_cnt !== 32'd2 || mispred_cnt !== 32'd1) begin
      failures++; $display("FAIL bne_cnt got=%0d/%0d exp=2/1", br_cnt, mispred_cnt);
    end
    issue(32'h240, 32'h0, OPC_ADD, 3'b000, 1'b0, 32'h244);
    checks++;
    if (e_stage_valid !== 1'b0) begin
      failures++; $display("FAIL bne_squash got=%h exp=0", e_stage_valid);
    end
  endtask

  task automatic test_non_jump();
    issue(32'h204, 32'h0, OPC_ADD, 3'b000, 1'b0, 32'h208);
    checks++;
    if (e_stage_valid !== 1'b1 || e_stage_is_jump_instr !== 1'b0) begin
      failures++;
      $display("FAIL add_dec got=%h/%h exp=1/0", e_stage_valid, e_stage_is_jump_instr);
    end
    checks++;
    if (e_pred_correct !== 1'b1 || e_flush !== 1'b0) begin
      failures++;
      $display("FAIL add_ok got=%h/%h exp=1/0", e_pred_correct, e_flush);
    end
    @(posedge clk); #1;
    checks++;
    if (br_cnt !== 32'd2 || mispred_cnt !== 32'd1) begin
      failures++; $display("FAIL add_cnt got=%0d/%0d exp=2/1", br_cnt, mispred_cnt);
    end
  endtask

  task automatic test_back_to_back();
    e_rs1_val = 32'hFFFF_FFFF; e_rs2_val = 32'd1;
    issue(32'h600, 32'h10, OPC_BRANCH, F3_BLT, 1'b1, 32'h610);
    checks++;
    if (e_actual_taken !== 1'b1 || e_flush !== 1'b0) begin
      failures++;
      $display("FAIL blt got=%h/%h exp=1/0", e_actual_taken, e_flush);
    end
    checks++;
    if (e_redirect_pc !== 32'h610) begin
      failures++; $display("FAIL blt_redir got=%h exp=610", e_redirect_pc);
    end
    issue(32'h700, 32'h10, OPC_BRANCH, F3_BLTU, 1'b0, 32'h704);
    checks++;
    if (e_actual_taken !== 1'b0 || e_pred_correct !== 1'b1) begin
      failures++;
      $display("FAIL bltu got=%h/%h exp=0/1", e_actual_taken, e_pred_correct);
    end
    checks++;
    if (e_redirect_pc !== 32'h704) begin
      failures++; $display("FAIL bltu_redir got=%h exp=704", e_redirect_pc);
    end
    @(posedge clk); #1;
    checks++;
    if (br_cnt !== 32'd4 || mispred_cnt !== 32'd1) begin
      failures++; $display("FAIL b2b_cnt got=%0d/%0d exp=4/1", br_cnt, mispred_cnt);
    end
  endtask

  task automatic test_jalr_stall();
    e_rs1_val = 32'h1003;
    issue(32'h500, 32'h4, OPC_JALR, 3'b000, 1'b1, 32'h1000);
    e_allow_in = 1'b0;
    checks++;
    if (e_flush !== 1'b1 || e_stage_valid !== 1'b1) begin
      failures++;
      $display("FAIL jalr_flush got=%h/%h exp=1/1", e_flush, e_stage_valid);
    end
    checks++;
    if (e_redirect_pc !== 32'h1006 || e_is_jalr !== 1'b1) begin
      failures++;
      $display("FAIL jalr_tgt got=%h/%h exp=1006/1", e_redirect_pc, e_is_jalr);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (e_flush !== 1'b0 || e_stage_valid !== 1'b0) begin
        failures++;
        $display("FAIL jalr_hold%0d got=%h/%h exp=0/0", i, e_flush, e_stage_valid);
      end
    end
    issue(32'h1000, 32'h0, OPC_ADD, 3'b000, 1'b0, 32'h1004);
    checks++;
    if (e_stage_valid !== 1'b0 || e_flush !== 1'b0) begin
      failures++;
      $display("FAIL jalr_squash got=%h/%h exp=0/0", e_stage_valid, e_flush);
    end
  endtask

  task automatic test_reset_mid();
    e_rs1_val = 32'd9; e_rs2_val = 32'd9;
    issue(32'h800, 32'h8, OPC_BRANCH, F3_BNE, 1'b1, 32'h808);
    e_allow_in = 1'b0;
    checks++;
    if (e_flush !== 1'b1) begin
      failures++; $display("FAIL mid_flush got=%h exp=1", e_flush);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (e_stage_valid !== 1'b0 || e_flush !== 1'b0 || e_pc !== 32'h0) begin
      failures++;
      $display("FAIL mid_rst got=%h/%h/%h exp=0/0/0", e_stage_valid, e_flush, e_pc);
    end
    checks++;
    if (br_cnt !== 32'h0 || mispred_cnt !== 32'h0 || e_redirect_pc !== 32'h0) begin
      failures++;
      $display("FAIL mid_rst_cnt got=%h/%h/%h exp=0/0/0",
               br_cnt, mispred_cnt, e_redirect_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    e_rs1_val = 32'd3; e_rs2_val = 32'd3;
    issue(32'h900, 32'h10, OPC_BRANCH, F3_BEQ, 1'b1, 32'h910);
    checks++;
    if (e_stage_valid !== 1'b1 || e_pc !== 32'h900 || e_flush !== 1'b0) begin
      failures++;
      $display("FAIL mid_accept got=%h/%h/%h exp=1/900/0",
               e_stage_valid, e_pc, e_flush);
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_bne_flush();
    test_non_jump();
    test_back_to_back();
    test_jalr_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/br_resolve_unit.md
Name: br_resolve_unit

Overview:
- Execute-stage consumer of the fetch-side branch predictor's speculative metadata.
- Latches each instruction's prediction snapshot from decode into an E-stage register.
- Resolves the real branch outcome from forwarded operands and raises a one-shot redirect/flush on mispredict.
- Drives the predictor's e_* training interface and keeps branch/mispredict counters.

Parameters:
- N, 12, GHR and LHT snapshot width.
- RAS_DEPTH, 16, RAS entries carried in the snapshot (32 bits each).
- RAS_W, 4, RAS stack-pointer width.
- SQUASH_DEPTH, 1, number of wrong-path decode handshakes dropped after a redirect (1..3).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- d_valid  in  1  decode presents an instruction
- e_allow_in  in  1  execute stage advances this cycle
- d_pc, d_pred_pc, d_imm  in  32 each  PC, predicted next PC, immediate
- d_opcode  in  7;  d_func3  in  3
- d_is_jump_instr, d_pred_taken, d_gshare_taken, d_local_taken  in  1 each
- d_ghr_snapshot, d_lht_snapshot  in  N;  d_ras_sp  in  RAS_W;  d_ras_snapshot  in  RAS_DEPTH*32
- e_rs1_val, e_rs2_val  in  32  forwarded operands for the current E instruction
- e_stage_valid, e_stage_is_jump_instr, e_actual_taken, e_pred_correct, e_is_cond_br, e_is_jalr  out  1
- e_pc, e_redirect_pc, e_imm  out  32;  e_func3  out  3
- e_train_ghr_snapshot, e_train_lht_snapshot  out  N;  e_train_ras_sp  out  RAS_W;  e_train_ras_snapshot  out  RAS_DEPTH*32
- e_train_gshare_taken, e_train_local_taken  out  1
- e_flush  out  1  one-cycle redirect and younger-instruction kill
- br_cnt, mispred_cnt  out  32  saturating counters

Behaviour:
- Reset (async): E register invalid; all outputs 0; FSM NORMAL; redirect_done=0; counters 0.
- E register:
  - Loads on e_allow_in.
  - Captures valid = d_valid & !e_flush & (state==NORMAL), plus all d_* fields.
  - A dropped capture loads a bubble (valid=0).
  - Holds when e_allow_in=0.
- Decode (combinational from the E register):
  - cond = opcode 1100011; jal = 1101111; jalr = 1100111.
  - e_stage_is_jump_instr = cond|jal|jalr; e_is_cond_br = cond; e_is_jalr = jalr.
- Outcome:
  - BEQ 000 / BNE 001: equality test.
  - BLT 100 / BGE 101: signed compare.
  - BLTU 110 / BGEU 111: unsigned compare.
  - func3 010/011: not taken.
  - jal and jalr: always taken.
- Target (32-bit, wrap-around ignored):
  - cond and jal: pc+imm.
  - jalr: (rs1+imm) & ~1.
  - e_redirect_pc = actual_taken ? target : pc+4.
- e_pred_correct:
  - Non-jump: 1.
  - Jump: (pred_taken==actual_taken) & (pred_pc==e_redirect_pc).
- e_flush:
  - Asserted when e_stage_valid & jump & !pred_correct & !redirect_done.
  - redirect_done is set on e_flush while E is held; it clears when E loads.
  - This gives exactly one pulse per instruction even under multi-cycle stall.
- e_stage_valid = E.valid & !redirect_done.
  - Training therefore fires once; the predictor sees e_stage_valid on the flush cycle.
- Squash FSM:
  - NORMAL → SQUASH on e_flush; load cnt=SQUASH_DEPTH.
  - In SQUASH, each d_valid & e_allow_in decrements cnt; at cnt 1→0 return to NORMAL.
  - A new e_flush while in SQUASH reloads cnt.
- Counters (update on e_stage_valid & jump & e_allow_in):
  - br_cnt+1; mispred_cnt+1 when !pred_correct.
  - Both saturate at 0xFFFFFFFF.
- Simultaneous flush and d_valid: the decode instruction is dropped and counts as the first squash handshake only if SQUASH_DEPTH consumption starts the next cycle. The younger instruction is killed directly; cnt begins decrementing next cycle.
- Reset mid-operation: everything returns to the reset state immediately; no pending flush survives.

Decomposition:
- Shared package br_pkg:
  - Opcode constants OPC_BRANCH, OPC_JAL, OPC_JALR.
  - func3 constants F3_BEQ..F3_BGEU.
  - Typedef for the speculative-metadata bundle, shared with the fetch side.
- One sub-module br_cmp: combinational func3/rs1/rs2 → taken.

Test Plan:
- BEQ at pc=0x100, imm=0x20, rs1=rs2=5, predicted taken to 0x120 → e_actual_taken=1, e_pred_correct=1, e_flush=0, br_cnt=1.
- BNE at pc=0x200, imm=0x40, rs1=rs2, predicted taken to 0x240 → e_redirect_pc=0x204, e_flush pulse 1 cycle, mispred_cnt=1; next decode handshake dropped (E valid=0).
- JALR with rs1=0x1003, imm=4, pred_pc=0x1000 → target 0x1006, e_flush=1; hold e_allow_in=0 for 3 cycles → e_flush and e_stage_valid high only on the first cycle.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken; BLTU with same operands → not taken.
- Non-jump ADD with pred_pc=pc+4 → e_stage_is_jump_instr=0, e_pred_correct=1, counters unchanged.
- Assert rst during SQUASH with E holding a mispredict → all outputs 0 asynchronously; after release the first d_valid is accepted.
